// File: rtl/gate_arpeggiator.sv
// Debounced active-low gate pin driving a repeating C-E-G arpeggio for one voice.
// A gate-low gap separates notes so the downstream ADSR retriggers on each note.
module gate_arpeggiator #(
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter int unsigned ON_CYCLES       = 2000000,
  parameter int unsigned GAP_CYCLES      = 16000,
  parameter logic [15:0] NOTE0           = 16'd4389,
  parameter logic [15:0] NOTE1           = 16'd5530,
  parameter logic [15:0] NOTE2           = 16'd6577
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger_n,
  output logic [15:0] tone_freq,
  output logic        gate,
  output logic [1:0]  step,
  output logic        busy
);

  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  logic             sync1, sync2;
  logic             pressed_s;
  logic             held_s;
  logic [DEB_W-1:0] deb_cnt;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      tone_d;
  logic             gate_d;
  logic [1:0]       step_d;
  logic [1:0]       step_inc;
  logic             busy_d;

  // Two-flop synchroniser; flops idle high so reset reads as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= trigger_n;
      sync2 <= sync1;
    end
  end

  assign pressed_s = ~sync2;

  // held_s follows pressed_s only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_s  <= 1'b0;
      deb_cnt <= '0;
    end else if (pressed_s != held_s) begin
      if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        held_s  <= pressed_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tone_freq <= NOTE0;
      gate      <= 1'b0;
      step      <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tone_freq <= tone_d;
      gate      <= gate_d;
      step      <= step_d;
      busy      <= busy_d;
    end
  end

  // Next state; release outranks counter expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (held_s) state_d = S_ON;
      S_ON: begin
        if (!held_s)            state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_GAP;
      end
      S_GAP: begin
        if (!held_s)            state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_ON;
      end
      default:                  state_d = S_IDLE;
    endcase
  end

  assign step_inc = (step == 2'd2) ? 2'd0 : step + 2'd1;

  // Next values of counter and outputs; tone_freq only moves when gate rises.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_freq;
    gate_d = gate;
    step_d = step;
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        gate_d = 1'b0;
        step_d = 2'd0;
        cnt_d  = '0;
        if (held_s) begin
          tone_d = NOTE0;
          gate_d = 1'b1;
          cnt_d  = CNT_W'(ON_CYCLES - 1);
        end
      end
      S_ON: begin
        if (!held_s) begin
          gate_d = 1'b0;
          step_d = 2'd0;
          cnt_d  = '0;
        end else if (cnt_q == '0) begin
          gate_d = 1'b0;
          cnt_d  = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (!held_s) begin
          gate_d = 1'b0;
          step_d = 2'd0;
          cnt_d  = '0;
        end else if (cnt_q == '0) begin
          step_d = step_inc;
          gate_d = 1'b1;
          cnt_d  = CNT_W'(ON_CYCLES - 1);
          case (step_inc)
            2'd1:    tone_d = NOTE1;
            2'd2:    tone_d = NOTE2;
            default: tone_d = NOTE0;
          endcase
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        gate_d = 1'b0;
        step_d = 2'd0;
        cnt_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_arpeggiator.sv
// Directed bench for gate_arpeggiator with short debounce/note timing.
module tb_gate_arpeggiator;

  localparam logic [15:0] N0 = 16'd4389;
  localparam logic [15:0] N1 = 16'd5530;
  localparam logic [15:0] N2 = 16'd6577;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger_n;
  logic [15:0] tone_freq;
  logic        gate;
  logic [1:0]  step;
  logic        busy;

  int errors = 0;
  int checks = 0;

  gate_arpeggiator #(
    .DEBOUNCE_CYCLES(4),
    .ON_CYCLES      (8),
    .GAP_CYCLES     (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trigger_n(trigger_n),
    .tone_freq(tone_freq),
    .gate     (gate),
    .step     (step),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [15:0] tone_exp);
    check({tag, ".gate"}, 32'(gate), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".step"}, 32'(step), 32'd0);
    check({tag, ".tone"}, 32'(tone_freq), 32'(tone_exp));
  endtask

  function automatic logic [15:0] note_of(input int s);
    case (s)
      1:       return N1;
      2:       return N2;
      default: return N0;
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    trigger_n = 1'b1;

    // Reset held with the pin toggling
    for (int i = 0; i < 6; i++) begin
      trigger_n = ~trigger_n;
      tick(1);
      check_idle("rst_hold", N0);
    end
    trigger_n = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(6);
    check_idle("rst_release", N0);

    // Bounce: 3-cycle low glitches never reach the FSM
    for (int g = 0; g < 4; g++) begin
      trigger_n = 1'b0;
      tick(3);
      trigger_n = 1'b1;
      tick(3);
      check("bounce.gate", 32'(gate), 32'd0);
      check("bounce.busy", 32'(busy), 32'd0);
      check("bounce.step", 32'(step), 32'd0);
    end
    tick(8);
    check_idle("bounce_after", N0);

    // Press: gate rises exactly 7 edges after the pin falls
    trigger_n = 1'b0;
    tick(6);
    check("press.gate6", 32'(gate), 32'd0);
    check("press.busy6", 32'(busy), 32'd0);
    tick(1);
    check("press.gate7", 32'(gate), 32'd1);
    check("press.tone7", 32'(tone_freq), 32'(N0));
    check("press.step7", 32'(step), 32'd0);
    check("press.busy7", 32'(busy), 32'd1);

    // Sequence: 8 high, 2 low, step cycles 0,1,2,0 every 10 edges
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      check("seq.gate", 32'(gate), ((i % 10) < 8) ? 32'd1 : 32'd0);
      check("seq.step", 32'(step), 32'((i / 10) % 3));
      check("seq.tone", 32'(tone_freq), 32'(note_of((i / 10) % 3)));
      check("seq.busy", 32'(busy), 32'd1);
    end

    // Release during ON at step 1 (gate rose on the last edge)
    check("rel.step_before", 32'(step), 32'd1);
    trigger_n = 1'b1;
    tick(6);
    check("rel.gate6", 32'(gate), 32'd1);
    check("rel.busy6", 32'(busy), 32'd1);
    tick(1);
    check_idle("rel7", N1);
    tick(5);
    check_idle("rel_idle", N1);

    // Re-press restarts at step 0; release aligned with ON expiry goes to IDLE
    trigger_n = 1'b0;
    tick(7);
    check("repress.gate", 32'(gate), 32'd1);
    check("repress.tone", 32'(tone_freq), 32'(N0));
    check("repress.step", 32'(step), 32'd0);
    tick(1);
    trigger_n = 1'b1;
    tick(6);
    check("coinc.gate_last_on", 32'(gate), 32'd1);
    tick(1);
    check_idle("coinc_exp", N0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_idle("coinc_after", N0);
    end

    // Async reset mid-GAP at step 2
    trigger_n = 1'b0;
    tick(7);
    check("gapr.gate_rise", 32'(gate), 32'd1);
    tick(28);
    check("gapr.step", 32'(step), 32'd2);
    check("gapr.gate", 32'(gate), 32'd0);
    check("gapr.busy", 32'(busy), 32'd1);
    check("gapr.tone", 32'(tone_freq), 32'(N2));
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("gapr_async", N0);
    tick(2);
    check_idle("gapr_held", N0);
    rst_n = 1'b1;
    tick(6);
    check_idle("gapr_debounce", N0);
    tick(1);
    check("restart.gate", 32'(gate), 32'd1);
    check("restart.tone", 32'(tone_freq), 32'(N0));
    check("restart.step", 32'(step), 32'd0);
    check("restart.busy", 32'(busy), 32'd1);
    tick(10);
    check("restart.tone2", 32'(tone_freq), 32'(N1));
    check("restart.step2", 32'(step), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
